// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select of a 2:1 data mux. Each owner is held for at most
// HOLD_MAX cycles under contention, and every owner change passes through one dead cycle.
module mux_sel_arbiter #(
   parameter int HOLD_MAX = 8,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req1,
   input  logic             req2,
   output logic             sel,
   output logic             gnt1,
   output logic             gnt2,
   output logic             busy,
   output logic [CNT_W-1:0] hold_cnt
);

   typedef enum logic [1:0] {IDLE, OWN1, OWN2, SWITCH} state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   state_t           state_q, state_d;
   logic             sel_q, sel_d;
   logic             gnt1_q, gnt1_d;
   logic             gnt2_q, gnt2_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             last_q, last_d;   // 0: source 1 owned last, 1: source 2 owned last

   logic grant_en, grant_src;
   logic own_src, own_req, oth_req, tgt_req;

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      gnt1_d     = 1'b0;
      gnt2_d     = 1'b0;
      hold_cnt_d = '0;
      last_d     = last_q;
      grant_en   = 1'b0;
      grant_src  = 1'b0;
      own_src    = (state_q == OWN2);
      own_req    = own_src ? req2 : req1;
      oth_req    = own_src ? req1 : req2;
      tgt_req    = sel_q ? req2 : req1;

      case (state_q)
         IDLE: begin
            if (req1 && req2) begin
               grant_en  = 1'b1;
               grant_src = ~last_q;
            end else if (req1 || req2) begin
               grant_en  = 1'b1;
               grant_src = req2;
            end
         end
         OWN1, OWN2: begin
            if (oth_req && (!own_req || hold_cnt_q == HOLD_LAST)) begin
               // Flip sel now so it is settled before the new owner's grant rises.
               state_d = SWITCH;
               sel_d   = ~own_src;
            end else if (!own_req) begin
               state_d = IDLE;
            end else begin
               gnt1_d     = ~own_src;
               gnt2_d     = own_src;
               hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
            end
         end
         SWITCH: begin
            if (tgt_req) begin
               grant_en  = 1'b1;
               grant_src = sel_q;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (grant_en) begin
         state_d = grant_src ? OWN2 : OWN1;
         sel_d   = grant_src;
         gnt1_d  = ~grant_src;
         gnt2_d  = grant_src;
         last_d  = grant_src;
      end

      busy_d = gnt1_d | gnt2_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sel_q      <= 1'b0;
         gnt1_q     <= 1'b0;
         gnt2_q     <= 1'b0;
         busy_q     <= 1'b0;
         hold_cnt_q <= '0;
         last_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         gnt1_q     <= gnt1_d;
         gnt2_q     <= gnt2_d;
         busy_q     <= busy_d;
         hold_cnt_q <= hold_cnt_d;
         last_q     <= last_d;
      end
   end

   assign sel      = sel_q;
   assign gnt1     = gnt1_q;
   assign gnt2     = gnt2_q;
   assign busy     = busy_q;
   assign hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: directed scenarios with literal expectations, then random
// request traffic compared every cycle against an ownership-level reference model.
module tb_mux_sel_arbiter;
   localparam int HOLD_MAX = 8;
   localparam int CNT_W    = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req1 = 1'b0;
   logic             req2 = 1'b0;
   logic             sel, gnt1, gnt2, busy;
   logic [CNT_W-1:0] hold_cnt;

   int ntest = 0;
   int nfail = 0;

   mux_sel_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .req1(req1), .req2(req2),
      .sel(sel), .gnt1(gnt1), .gnt2(gnt2), .busy(busy), .hold_cnt(hold_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: who owns the mux, for how long, and any pending hand-over.
   int m_owner = 0;   // 0 none, else 1 or 2
   int m_run   = 0;   // cycles held so far, unsaturated
   int m_last  = 2;
   int m_tgt   = 0;
   bit m_dead  = 0;
   bit m_sel   = 0;
   bit m_live  = 0;

   always @(posedge clk) begin
      bit r [1:2];
      int o, x, pick;
      r[1] = req1;
      r[2] = req2;
      m_live <= 1'b1;
      if (!rst_n) begin
         m_owner = 0; m_run = 0; m_last = 2; m_dead = 0; m_sel = 0;
      end else if (m_dead) begin
         m_dead = 0;
         if (r[m_tgt]) begin
            m_owner = m_tgt; m_run = 0; m_last = m_tgt;
         end else begin
            m_owner = 0;
         end
      end else if (m_owner != 0) begin
         o = m_owner;
         x = 3 - m_owner;
         if (r[x] && (!r[o] || m_run >= HOLD_MAX - 1)) begin
            m_owner = 0; m_dead = 1; m_tgt = x; m_sel = (x == 2);
         end else if (!r[o]) begin
            m_owner = 0;
         end else begin
            m_run++;
         end
      end else begin
         pick = 0;
         if (r[1] && r[2]) pick = (m_last == 1) ? 2 : 1;
         else if (r[1])    pick = 1;
         else if (r[2])    pick = 2;
         if (pick != 0) begin
            m_owner = pick; m_run = 0; m_last = pick; m_sel = (pick == 2);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      ntest++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      int eh;
      if (m_live) begin
         eh = (m_owner == 0) ? 0 : ((m_run < HOLD_MAX - 1) ? m_run : HOLD_MAX - 1);
         chk("model_sel",  int'(sel),      int'(m_sel));
         chk("model_gnt1", int'(gnt1),     int'(m_owner == 1));
         chk("model_gnt2", int'(gnt2),     int'(m_owner == 2));
         chk("model_busy", int'(busy),     int'(m_owner != 0));
         chk("model_hold", int'(hold_cnt), eh);
         if (gnt1 && gnt2) chk("gnt_exclusive", 1, 0);
      end
   end

   // Apply inputs, let one edge act on them, return at the following negedge.
   task automatic step(input logic rn, input logic r1, input logic r2);
      rst_n = rn; req1 = r1; req2 = r2;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      // Reset held with both requests up.
      step(0, 1, 1);
      step(0, 1, 1);
      chk("rst_out", int'({sel, gnt1, gnt2, busy}), 0);
      chk("rst_hold", int'(hold_cnt), 0);

      // Lone requester: unbounded ownership, saturating counter.
      step(1, 1, 0);
      chk("solo_gnt1", int'({gnt1, busy}), 3);
      chk("solo_hold0", int'(hold_cnt), 0);
      for (int i = 0; i < 19; i++) step(1, 1, 0);
      chk("solo_sat", int'(hold_cnt), 7);
      chk("solo_still", int'(gnt1), 1);
      step(1, 0, 0);
      chk("solo_drop", int'({sel, gnt1, gnt2}), 0);

      // Continuous dual request after reset: 8 x gnt1, dead, 8 x gnt2, dead, gnt1.
      step(0, 0, 0);
      for (int k = 1; k <= 19; k++) begin
         int exp;
         step(1, 1, 1);
         if (k <= 8 || k == 19) exp = 3'b010;
         else if (k == 9)       exp = 3'b100;
         else if (k <= 17)      exp = 3'b101;
         else                   exp = 3'b000;
         chk("rr_pattern", int'({sel, gnt1, gnt2}), exp);
      end

      // req2 alone from IDLE with sel=0.
      step(0, 0, 0);
      step(1, 0, 1);
      chk("req2_first", int'({sel, gnt2, busy}), 7);
      chk("req2_hold", int'(hold_cnt), 0);

      // Early release while the other side waits.
      step(0, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 1, 0);
      chk("own1_h3", int'(hold_cnt), 3);
      step(1, 0, 1);
      chk("rel_switch", int'({sel, gnt1, gnt2}), 3'b100);
      step(1, 0, 1);
      chk("rel_gnt2", int'({sel, gnt2}), 3);
      // Target withdraws during the dead cycle.
      step(0, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 1, 0);
      step(1, 0, 1);
      step(1, 0, 0);
      chk("sw_abort", int'({sel, gnt1, gnt2, busy}), 4'b1000);

      // Reset mid-ownership.
      step(0, 0, 0);
      for (int i = 0; i < 6; i++) step(1, 0, 1);
      chk("own2_h5", int'(hold_cnt), 5);
      step(0, 1, 1);
      chk("mid_rst", int'({sel, gnt1, gnt2, hold_cnt}), 0);
      step(1, 1, 1);
      chk("post_rst_tie", int'({sel, gnt1, gnt2}), 3'b010);

      // Random traffic with sticky requests and occasional resets.
      for (int i = 0; i < 4000; i++) begin
         logic r1, r2, rn;
         r1 = ($urandom_range(0, 9) < 2) ? ~req1 : req1;
         r2 = ($urandom_range(0, 9) < 2) ? ~req2 : req2;
         rn = ($urandom_range(0, 99) != 0);
         step(rn, r1, r2);
      end

      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end
endmodule
